dmem_axi_master: RTL and testbench

DMEM_AXI_MASTER -- requirements
Module: dmem_axi_master

---
 rtl/dmem_axi_master_pkg.sv | 24 ++
 rtl/dmem_axi_master.sv | 200 ++++++++++++++++++++
 tb/tb_dmem_axi_master.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_axi_master_pkg.sv
// Shared widths, response/protection constants and FSM encoding for dmem_axi_master.
// The optional response timeout is enabled with KRV_AXI_MASTER_TIMEOUT_EN.
package dmem_axi_master_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int STRB_WIDTH     = DATA_WIDTH / 8;

    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4
    } state_e;

    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/dmem_axi_master.sv
// Single-outstanding data-memory request port bridged onto an AXI4-lite master.
// Define KRV_AXI_MASTER_TIMEOUT_EN to abort B/R waits after TIMEOUT_CYCLES cycles.
module dmem_axi_master
    import dmem_axi_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
    input  logic                      req_rd0_wr1,
    input  logic [DATA_WIDTH-1:0]     req_write_data,
    input  logic [STRB_WIDTH-1:0]     req_byte_strobe,

    output logic                      resp_valid,
    output logic [DATA_WIDTH-1:0]     resp_read_data,
    output logic                      resp_err,

    output logic                      AWVALID,
    input  logic                      AWREADY,
    output logic [AXI_ADDR_WIDTH-1:0] AWADDR,
    output logic [2:0]                AWPROT,
    output logic                      WVALID,
    input  logic                      WREADY,
    output logic [DATA_WIDTH-1:0]     WDATA,
    output logic [STRB_WIDTH-1:0]     WSTRB,
    input  logic                      BVALID,
    input  logic [1:0]                BRESP,
    output logic                      BREADY,

    output logic                      ARVALID,
    input  logic                      ARREADY,
    output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    output logic [2:0]                ARPROT,
    input  logic                      RVALID,
    input  logic [DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                RRESP,
    output logic                      RREADY
);

    // A zero budget would expire on the very first wait cycle; keep it at least 1.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_invalid
    end

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]     wstrb_q, wstrb_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic                      resp_valid_q, resp_valid_d;
    logic                      resp_err_q, resp_err_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic                      timeout_hit;
    logic                      aw_fire, w_fire;

`ifdef KRV_AXI_MASTER_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               waiting;

    assign waiting     = (state_q == ST_WR_RESP) || (state_q == ST_RD_DATA);
    assign timeout_hit = waiting && (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    // Counter is zero on entry to a wait state because it only advances while waiting.
    always_comb begin
        timer_d = '0;
        if (waiting && !timeout_hit) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign aw_fire = AWVALID && AWREADY;
    assign w_fire  = WVALID && WREADY;

    // NOTE: every variable gets its hold/default value first so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        rdata_d      = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d = req_addr;
                    if (req_rd0_wr1) begin
                        wdata_d   = req_write_data;
                        wstrb_d   = req_byte_strobe;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = ST_WR_REQ;
                    end else begin
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                if (aw_fire) aw_done_d = 1'b1;
                if (w_fire)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (BVALID) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b1;
                    resp_err_d   = resp_is_error(BRESP);
                end else if (timeout_hit) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end
            end
            ST_RD_REQ: begin
                if (ARREADY) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (RVALID) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b1;
                    resp_err_d   = resp_is_error(RRESP);
                    rdata_d      = RDATA;
                end else if (timeout_hit) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    // NOTE: every register here is reset; the block is small and a clean post-reset read value is required.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rdata_q      <= rdata_d;
        end
    end

    // Handshake signals decode straight from the state register, so reset clears them at once.
    assign req_ready      = ARESETn && (state_q == ST_IDLE);
    assign AWVALID        = (state_q == ST_WR_REQ) && !aw_done_q;
    assign WVALID         = (state_q == ST_WR_REQ) && !w_done_q;
    assign BREADY         = (state_q == ST_WR_RESP);
    assign ARVALID        = (state_q == ST_RD_REQ);
    assign RREADY         = (state_q == ST_RD_DATA);

    assign AWADDR         = addr_q;
    assign ARADDR         = addr_q;
    assign WDATA          = wdata_q;
    assign WSTRB          = wstrb_q;
    assign AWPROT         = AXI_PROT_DEFAULT;
    assign ARPROT         = AXI_PROT_DEFAULT;

    assign resp_valid     = resp_valid_q;
    assign resp_err       = resp_err_q;
    assign resp_read_data = rdata_q;

endmodule

// File: tb/tb_dmem_axi_master.sv
// Directed bench for dmem_axi_master: writes, skewed handshakes, reads, back-to-back, wait/timeout, reset.
// Build with KRV_AXI_MASTER_TIMEOUT_EN to exercise the timeout path instead of the indefinite wait.
module tb_dmem_axi_master;

    logic        ACLK;
    logic        ARESETn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_rd0_wr1;
    logic [31:0] req_write_data;
    logic [3:0]  req_byte_strobe;
    logic        resp_valid;
    logic [31:0] resp_read_data;
    logic        resp_err;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    int n_cmp  = 0;
    int n_fail = 0;

    dmem_axi_master #(.TIMEOUT_CYCLES(8)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_rd0_wr1(req_rd0_wr1), .req_write_data(req_write_data),
        .req_byte_strobe(req_byte_strobe),
        .resp_valid(resp_valid), .resp_read_data(resp_read_data), .resp_err(resp_err),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled and inputs driven 1 time unit after the rising edge.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        ARESETn = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_rd0_wr1 = 1'b0;
        req_write_data = '0; req_byte_strobe = '0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;

        // Reset state
        #1;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_awvalid", AWVALID, 1'b0);
        check("rst_arvalid", ARVALID, 1'b0);
        check("rst_rdata", resp_read_data, 32'h0);
        repeat (2) @(posedge ACLK);
        #2 ARESETn = 1'b1;
        #1;
        check("post_rst_req_ready", req_ready, 1'b1);

        // Zero-wait write
        req_valid = 1'b1; req_rd0_wr1 = 1'b1; req_addr = 32'h0000_1000;
        req_write_data = 32'hDEAD_BEEF; req_byte_strobe = 4'hF;
        AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
        tick();
        req_valid = 1'b0;
        check("zw_c1_awvalid", AWVALID, 1'b1);
        check("zw_c1_wvalid", WVALID, 1'b1);
        check("zw_c1_awaddr", AWADDR, 32'h0000_1000);
        check("zw_c1_wdata", WDATA, 32'hDEAD_BEEF);
        check("zw_c1_wstrb", WSTRB, 4'hF);
        check("zw_c1_awprot", AWPROT, 3'b000);
        check("zw_c1_req_ready", req_ready, 1'b0);
        check("zw_c1_bready", BREADY, 1'b0);
        tick();
        check("zw_c2_bready", BREADY, 1'b1);
        check("zw_c2_awvalid", AWVALID, 1'b0);
        check("zw_c2_resp_valid", resp_valid, 1'b0);
        tick();
        check("zw_c3_resp_valid", resp_valid, 1'b1);
        check("zw_c3_resp_err", resp_err, 1'b0);
        check("zw_c3_req_ready", req_ready, 1'b1);
        check("zw_c3_bready", BREADY, 1'b0);
        BVALID = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
        tick();
        check("zw_c4_resp_valid", resp_valid, 1'b0);

        // Skewed write: W handshake 3 cycles before AW
        req_valid = 1'b1; req_rd0_wr1 = 1'b1; req_addr = 32'h0000_2000;
        req_write_data = 32'h1122_3344; req_byte_strobe = 4'h3;
        WREADY = 1'b1;
        tick();
        req_valid = 1'b0;
        check("sk_c1_awvalid", AWVALID, 1'b1);
        check("sk_c1_wvalid", WVALID, 1'b1);
        tick();
        WREADY = 1'b0;
        check("sk_c2_wvalid", WVALID, 1'b0);
        check("sk_c2_awvalid", AWVALID, 1'b1);
        check("sk_c2_bready", BREADY, 1'b0);
        tick();
        check("sk_c3_awvalid", AWVALID, 1'b1);
        check("sk_c3_awaddr", AWADDR, 32'h0000_2000);
        tick();
        check("sk_c4_awvalid", AWVALID, 1'b1);
        check("sk_c4_bready", BREADY, 1'b0);
        AWREADY = 1'b1;
        tick();
        AWREADY = 1'b0;
        check("sk_c5_awvalid", AWVALID, 1'b0);
        check("sk_c5_bready", BREADY, 1'b1);
        BVALID = 1'b1; BRESP = 2'b00;
        tick();
        BVALID = 1'b0;
        check("sk_resp_valid", resp_valid, 1'b1);
        check("sk_resp_err", resp_err, 1'b0);
        check("sk_rdata_held", resp_read_data, 32'h0);

        // Read with RVALID delayed 5 cycles, SLVERR response
        req_valid = 1'b1; req_rd0_wr1 = 1'b0; req_addr = 32'h0000_3000;
        ARREADY = 1'b1;
        tick();
        req_valid = 1'b0;
        check("rd_c1_arvalid", ARVALID, 1'b1);
        check("rd_c1_araddr", ARADDR, 32'h0000_3000);
        check("rd_c1_arprot", ARPROT, 3'b000);
        check("rd_c1_rready", RREADY, 1'b0);
        tick();
        ARREADY = 1'b0;
        check("rd_c2_arvalid", ARVALID, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rd_wait%0d_rready", i), RREADY, 1'b1);
            check($sformatf("rd_wait%0d_resp_valid", i), resp_valid, 1'b0);
            tick();
        end
        RVALID = 1'b1; RDATA = 32'h1234_5678; RRESP = 2'b10;
        tick();
        RVALID = 1'b0; RDATA = 32'hFFFF_FFFF; RRESP = 2'b00;
        check("rd_resp_valid", resp_valid, 1'b1);
        check("rd_resp_err", resp_err, 1'b1);
        check("rd_resp_data", resp_read_data, 32'h1234_5678);
        check("rd_req_ready", req_ready, 1'b1);
        tick();
        check("rd_pulse_end", resp_valid, 1'b0);
        check("rd_data_held", resp_read_data, 32'h1234_5678);

        // Back-to-back reads with req_valid held
        req_valid = 1'b1; req_rd0_wr1 = 1'b0; req_addr = 32'h0000_4000;
        ARREADY = 1'b1; RVALID = 1'b1; RDATA = 32'hAAAA_0001; RRESP = 2'b00;
        tick();
        req_addr = 32'h0000_5000;
        check("bb_c1_arvalid", ARVALID, 1'b1);
        check("bb_c1_araddr", ARADDR, 32'h0000_4000);
        check("bb_c1_req_ready", req_ready, 1'b0);
        tick();
        check("bb_c2_rready", RREADY, 1'b1);
        check("bb_c2_arvalid", ARVALID, 1'b0);
        tick();
        check("bb_c3_resp_valid", resp_valid, 1'b1);
        check("bb_c3_rdata", resp_read_data, 32'hAAAA_0001);
        check("bb_c3_req_ready", req_ready, 1'b1);
        check("bb_c3_arvalid", ARVALID, 1'b0);
        tick();
        req_valid = 1'b0;
        RDATA = 32'hBBBB_0002;
        check("bb_c4_arvalid", ARVALID, 1'b1);
        check("bb_c4_araddr", ARADDR, 32'h0000_5000);
        check("bb_c4_resp_valid", resp_valid, 1'b0);
        tick();
        check("bb_c5_rready", RREADY, 1'b1);
        tick();
        RVALID = 1'b0; ARREADY = 1'b0;
        check("bb_c6_resp_valid", resp_valid, 1'b1);
        check("bb_c6_rdata", resp_read_data, 32'hBBBB_0002);
        tick();
        check("bb_c7_resp_valid", resp_valid, 1'b0);

        // Write whose B response never arrives on time
        req_valid = 1'b1; req_rd0_wr1 = 1'b1; req_addr = 32'h0000_6000;
        req_write_data = 32'h5555_AAAA; req_byte_strobe = 4'hC;
        AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        AWREADY = 1'b0; WREADY = 1'b0;
`ifdef KRV_AXI_MASTER_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            check($sformatf("to_wait%0d_bready", i), BREADY, 1'b1);
            check($sformatf("to_wait%0d_resp_valid", i), resp_valid, 1'b0);
            tick();
        end
        check("to_resp_valid", resp_valid, 1'b1);
        check("to_resp_err", resp_err, 1'b1);
        check("to_bready_dropped", BREADY, 1'b0);
        tick();
        check("to_next_req_ready", req_ready, 1'b1);
        check("to_next_resp_valid", resp_valid, 1'b0);
`else
        for (int i = 0; i < 20; i++) begin
            check($sformatf("nt_wait%0d_bready", i), BREADY, 1'b1);
            check($sformatf("nt_wait%0d_resp_valid", i), resp_valid, 1'b0);
            tick();
        end
        BVALID = 1'b1; BRESP = 2'b11;
        tick();
        BVALID = 1'b0; BRESP = 2'b00;
        check("nt_resp_valid", resp_valid, 1'b1);
        check("nt_resp_err", resp_err, 1'b1);
        tick();
        check("nt_next_req_ready", req_ready, 1'b1);
`endif

        // Reset asserted while waiting in RD_DATA
        req_valid = 1'b1; req_rd0_wr1 = 1'b0; req_addr = 32'h0000_7000;
        ARREADY = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        ARREADY = 1'b0;
        check("rr_rready_before", RREADY, 1'b1);
        #2 ARESETn = 1'b0;
        #1;
        check("rr_arvalid", ARVALID, 1'b0);
        check("rr_rready", RREADY, 1'b0);
        check("rr_resp_valid", resp_valid, 1'b0);
        check("rr_rdata_cleared", resp_read_data, 32'h0);
        check("rr_req_ready_low", req_ready, 1'b0);
        RVALID = 1'b1; RDATA = 32'hCAFE_F00D;
        @(posedge ACLK);
        #3 ARESETn = 1'b1;
        RVALID = 1'b0;
        #1;
        check("rr_release_req_ready", req_ready, 1'b1);
        check("rr_release_resp_valid", resp_valid, 1'b0);
        tick();
        check("rr_no_late_pulse", resp_valid, 1'b0);
        check("rr_idle_rready", RREADY, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
